// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port and valid/ready stream bundle (m_last with FIFO_READER_LAST_EN)
interface fifo_stream_reader_if #(parameter int DATA_WIDTH = 16);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
`ifdef FIFO_READER_LAST_EN
  logic                  m_last;
  modport master (input fifo_empty, fifo_data, fifo_valid, m_ready,
                  output fifo_rd_en, m_data, m_valid, m_last);
  modport slave  (output fifo_empty, fifo_data, fifo_valid, m_ready,
                  input fifo_rd_en, m_data, m_valid, m_last);
`else
  modport master (input fifo_empty, fifo_data, fifo_valid, m_ready,
                  output fifo_rd_en, m_data, m_valid);
  modport slave  (output fifo_empty, fifo_data, fifo_valid, m_ready,
                  input fifo_rd_en, m_data, m_valid);
`endif
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: FIFO read controller with 2-entry skid buffer; FIFO_READER_LAST_EN adds m_last bursts
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] count, count_n, tail;
  logic inflight, inflight_n, rst_d, pop, fv, cap, bad, empty_n;
  logic [DATA_WIDTH-1:0] d0, d1, d0_n, d1_n;
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("BURST_LEN must be >= 1");
  end
  assign bus.m_valid = count != 2'd0;
  assign bus.m_data  = d0;
  assign busy        = state != IDLE;
  always_comb begin
    pop = bus.m_valid & bus.m_ready;
    bus.fifo_rd_en = !rst & enable & !bus.fifo_empty &
                     ({1'b0, count} + {2'b0, inflight} - {2'b0, pop} < 3'd2);
    fv = bus.fifo_valid & !rst_d;
    cap = fv & inflight & (count != 2'd2 | pop);
    bad = fv & !cap;
    count_n = count + {1'b0, cap} - {1'b0, pop};
    inflight_n = bus.fifo_rd_en | (inflight & !bus.fifo_valid);
    tail = count - {1'b0, pop};
    d0_n = cap & tail == 2'd0 ? bus.fifo_data : pop ? d1 : d0;
    d1_n = cap & tail == 2'd1 ? bus.fifo_data : d1;
    empty_n = count_n == 2'd0 & !inflight_n;
    state_n = state == IDLE ? (enable ? RUN : IDLE) : enable ? RUN : empty_n ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      inflight   <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      beat_count <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      inflight   <= inflight_n;
      d0         <= d0_n;
      d1         <= d1_n;
      beat_count <= beat_count + CNT_WIDTH'(pop);
      err        <= err | bad;
    end
  end
`ifdef FIFO_READER_LAST_EN
  localparam int BW = $clog2(BURST_LEN + 1);
  logic [BW-1:0] burst_cnt;
  assign bus.m_last = bus.m_valid & (burst_cnt == BW'(BURST_LEN - 1));
  always_ff @(posedge clk) begin
    if (rst) burst_cnt <= '0;
    else if (pop) burst_cnt <= bus.m_last ? '0 : burst_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed tests with a FIFO model and an in-order scoreboard
module tb_fifo_stream_reader;
`ifdef FIFO_READER_LAST_EN
  localparam int BL = 4;
`else
  localparam int BL = 8;
`endif
  logic clk = 0, rst = 1, enable = 0, flush = 1, spur = 0, fv_r = 0;
  logic busy, err;
  logic [15:0] beat_count;
  logic [15:0] mem [0:63];
  logic [15:0] exp_q [$];
  int wp = 0, rp = 0, cyc = 0, checks = 0, errors = 0;
  int rd_cnt = 0, pop_idx = 0, n_last = 0, first_rd = -1, first_v = -1, last_v = -1;
  fifo_stream_reader_if #(.DATA_WIDTH(16)) bus ();
  fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(16), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .busy(busy), .beat_count(beat_count), .err(err)
  );
  always #5 clk = ~clk;
  assign bus.fifo_empty = wp == rp;
  assign bus.fifo_valid = fv_r | spur;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    fv_r <= 1'b0;
    if (flush) rp <= wp;
    else if (bus.fifo_rd_en && rp != wp) begin
      bus.fifo_data <= mem[rp % 64];
      fv_r <= 1'b1;
      rp <= rp + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.fifo_rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (bus.m_valid && bus.m_ready) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (exp_q.size() == 0) chk("extra_beat", {16'd0, bus.m_data}, 32'hffff_ffff);
      else chk("data", {16'd0, bus.m_data}, {16'd0, exp_q.pop_front()});
`ifdef FIFO_READER_LAST_EN
      chk("m_last", {31'd0, bus.m_last}, {31'd0, pop_idx % BL == BL - 1});
      if (bus.m_last) n_last++;
`endif
      pop_idx++;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [15:0] v);
    mem[wp % 64] = v;
    wp++;
    exp_q.push_back(v);
  endtask
  task automatic do_reset();
    rst = 1; flush = 1; enable = 0; bus.m_ready = 0;
    step(2);
    exp_q.delete();
    chk("rst_m_valid", {31'd0, bus.m_valid}, 0);
    chk("rst_m_data", {16'd0, bus.m_data}, 0);
    chk("rst_beat", {16'd0, beat_count}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 0);
    rst = 0; flush = 0;
    rd_cnt = 0; pop_idx = 0; n_last = 0; first_rd = -1; first_v = -1; last_v = -1;
  endtask
  initial begin
    bus.m_ready = 0;
    bus.fifo_data = '0;
    // full-throughput burst of four
    do_reset();
    for (int i = 1; i <= 4; i++) push(16'(i));
    bus.m_ready = 1; enable = 1;
    step(8);
    chk("t1_latency", first_v - first_rd, 2);
    chk("t1_back_to_back", last_v - first_v, 3);
    chk("t1_rd_cnt", rd_cnt, 4);
    chk("t1_beats", {16'd0, beat_count}, 4);
    chk("t1_err", {31'd0, err}, 0);
    chk("t1_drained", exp_q.size(), 0);
    // backpressure: only two reads, head held
    do_reset();
    for (int i = 1; i <= 5; i++) push(16'(i));
    enable = 1;
    step(6);
    chk("t2_rd_cnt", rd_cnt, 2);
    chk("t2_m_valid", {31'd0, bus.m_valid}, 1);
    chk("t2_hold_a", {16'd0, bus.m_data}, 1);
    step(3);
    chk("t2_hold_b", {16'd0, bus.m_data}, 1);
    bus.m_ready = 1;
    step(10);
    chk("t2_beats", {16'd0, beat_count}, 5);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_err", {31'd0, err}, 0);
    // m_ready toggling every cycle
    do_reset();
    for (int i = 1; i <= 10; i++) push(16'(i));
    enable = 1;
    for (int i = 0; i < 40; i++) begin
      bus.m_ready = ~bus.m_ready;
      step(1);
    end
    chk("t3_beats", {16'd0, beat_count}, 10);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_err", {31'd0, err}, 0);
    // drop enable with one word buffered and one in flight
    do_reset();
    for (int i = 1; i <= 3; i++) push(16'(i));
    enable = 1;
    step(2);
    enable = 0; bus.m_ready = 1;
    #1;
    chk("t4_no_rd", {31'd0, bus.fifo_rd_en}, 0);
    chk("t4_busy_run", {31'd0, busy}, 1);
    step(1);
    chk("t4_busy_drain", {31'd0, busy}, 1);
    chk("t4_valid_drain", {31'd0, bus.m_valid}, 1);
    step(1);
    chk("t4_idle", {31'd0, busy}, 0);
    chk("t4_beats", {16'd0, beat_count}, 2);
    chk("t4_rd_cnt", rd_cnt, 2);
    chk("t4_left", exp_q.size(), 1);
    // reset with buffered words, ignored and spurious fifo_valid
    do_reset();
    push(16'h0011); push(16'h0022);
    enable = 1;
    step(5);
    chk("t5_buffered", {31'd0, bus.m_valid}, 1);
    enable = 0; rst = 1;
    step(2);
    exp_q.delete();
    chk("t5_rst_valid", {31'd0, bus.m_valid}, 0);
    chk("t5_rst_beat", {16'd0, beat_count}, 0);
    rst = 0; spur = 1;
    step(1);
    spur = 0;
    #1;
    chk("t5_ignored", {31'd0, err}, 0);
    step(1);
    spur = 1;
    step(1);
    spur = 0;
    #1;
    chk("t5_spurious", {31'd0, err}, 1);
    step(3);
    chk("t5_sticky", {31'd0, err}, 1);
    chk("t5_no_beat", {16'd0, beat_count}, 0);
`ifdef FIFO_READER_LAST_EN
    // bursts of four over nine beats
    do_reset();
    for (int i = 1; i <= 9; i++) push(16'(i));
    bus.m_ready = 1; enable = 1;
    step(14);
    chk("t6_beats", {16'd0, beat_count}, 9);
    chk("t6_n_last", n_last, 2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
